reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Round-robin write arbiter and controller for a bank of eight 8-bit registers with enable and synchronous reset. Up to four requesters compete for the single bank write port through a req/gnt handshake. Each granted request commits one byte to one register. A registered read port and a bank-wide clear sit alongside. The block sits between datapath sequencers and the shared register storage, and is the only agent driving register enables.

## Interface
- NREQ, 4, number of requesters (fixed at 4; pointer and grant logic sized for it)
- NREGS, 8, number of 8-bit registers in the bank (address width 3)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  4  per-requester write request, bit i = requester i
- waddr  in  12  flattened write addresses, requester i at [3i+2:3i]
- wdata  in  32  flattened write data, requester i at [8i+7:8i]
- gnt  out  4  one-hot grant, registered, at most one bit set
- busy  out  1  high while state = GRANT
- clr  in  1  synchronous clear of all bank registers
- raddr  in  3  read address
- rdata  out  8  registered read data
- wr_count  out  16  number of committed writes, saturating

## Operation
- State machine: IDLE, GRANT.
- IDLE:
  - If `req != 0`, choose a winner round-robin, starting the search at `ptr` (ptr, ptr+1, … mod 4).
  - Register `gnt` = one-hot of the winner and go to GRANT.
  - If `req == 0`, stay in IDLE with `gnt = 0`.
- GRANT:
  - At the closing clock edge, write `wdata[winner]` into bank register `waddr[winner]`.
  - At the same edge: `ptr <= winner+1` (mod 4), `gnt <= 0`, `wr_count` increments (holds at 16'hFFFF), next state IDLE.
- Requester rules:
  - Hold req, waddr and wdata stable from assertion until the cycle gnt is seen high.
  - Deassert req in the cycle after gnt unless another write is wanted; a still-high req is treated as a new request.
- Fairness: a requester continuously requesting is granted within 4 grants.
- clr:
  - Zeroes all 8 registers at the edge.
  - Does not block arbitration.
  - If clr and a GRANT write coincide, all registers clear except the written address, which takes the write data.
- Read port: `rdata <= bank[raddr]` each edge.
  - Bypass: if a write to `raddr` commits at the same edge, rdata takes the write data.
  - If clr with no matching write, rdata takes 0.
- waddr bits are exactly 3 wide, so no out-of-range addresses exist.
- Reset values: state IDLE, gnt 0, busy 0, ptr 0, all bank registers 8'h00, rdata 8'h00, wr_count 0.
- rst overrides clr, req and any in-progress GRANT; a write pending at rst is discarded and not counted.

## Timing
- Request to grant: req high in IDLE cycle t gives gnt high in cycle t+1.
- Write visibility:
  - The write lands at the edge ending cycle t+1.
  - rdata reflects it in cycle t+2 with a matching raddr, either via the bypass or from storage.
- Throughput: one write per 2 cycles at most (IDLE/GRANT alternation under constant req).
- busy equals the registered GRANT state; gnt is high only while busy.
- Read latency: 1 cycle from raddr to rdata.
- req changes during GRANT do not affect the current grant.

## Test plan
- After rst, req=4'b0001, waddr0=3, wdata0=8'hA5:
  - gnt=0001 one cycle later, then bank[3]=A5.
  - raddr=3 gives rdata=A5.
  - wr_count=1.
- req=4'b1111 held constant, ptr=0:
  - Grants cycle 0001, 0010, 0100, 1000, 0001 on alternating cycles.
  - Never two bits set.
- Requester 2 granted last, then req=4'b0101:
  - Next grant is 0001 (search starts at 3, wraps to 0).
  - Following grant is 0100.
- clr asserted in the GRANT cycle of a write of 8'h3C to reg 5, with all registers previously 8'hFF:
  - All registers read 00 except reg 5 = 3C.
- raddr=6 held while reg 6 is written with 8'h77:
  - rdata=77 in the cycle after the commit edge (bypass); previous value before.
- rst asserted during GRANT of a pending write:
  - Write discarded; gnt, busy, wr_count and rdata are 0.
  - ptr=0.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin write arbiter for an 8x8-bit register bank
module reg_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  output logic [3:0]  gnt,
  output logic        busy,
  input  logic        clr,
  input  logic [2:0]  raddr,
  output logic [7:0]  rdata,
  output logic [15:0] wr_count
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t      r_state;
  logic [3:0]  r_gnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_win;
  logic [7:0]  r_bank [NREGS];
  logic [7:0]  r_rdata;
  logic [15:0] r_wr_count;

  logic [1:0]  w_win;
  logic        w_commit;
  logic [2:0]  w_waddr;
  logic [7:0]  w_wdata;

  assign gnt      = r_gnt;
  assign busy     = (r_state == S_GRANT);
  assign rdata    = r_rdata;
  assign wr_count = r_wr_count;

  // The write port is driven only in GRANT, using the latched winner's lanes.
  assign w_commit = (r_state == S_GRANT);

  // Round-robin pick: the lowest offset from r_ptr with req set wins (scan high to low so it lands last).
  always_comb begin
    w_win = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_win = r_ptr + 2'(i);
      end
    end
  end

  // Select the granted requester's address and data lanes.
  always_comb begin
    w_waddr = 3'd0;
    w_wdata = 8'd0;
    case (r_win)
      2'd0: begin w_waddr = waddr[2:0];  w_wdata = wdata[7:0];   end
      2'd1: begin w_waddr = waddr[5:3];  w_wdata = wdata[15:8];  end
      2'd2: begin w_waddr = waddr[8:6];  w_wdata = wdata[23:16]; end
      default: begin w_waddr = waddr[11:9]; w_wdata = wdata[31:24]; end
    endcase
  end

  // Arbitration FSM: IDLE picks a winner, GRANT commits it and advances the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 4'd0;
      r_ptr      <= 2'd0;
      r_win      <= 2'd0;
      r_wr_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 4'd0) begin
            r_win   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_state <= S_GRANT;
          end else begin
            r_gnt <= 4'd0;
          end
        end
        default: begin
          r_ptr   <= r_win + 2'd1;
          r_gnt   <= 4'd0;
          r_state <= S_IDLE;
          if (r_wr_count != 16'hFFFF) begin
            r_wr_count <= r_wr_count + 16'd1;
          end
        end
      endcase
    end
  end

  // Bank storage: a committing write beats the bank-wide clear for its own address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        r_bank[i] <= 8'd0;
      end else if (w_commit && (w_waddr == 3'(i))) begin
        r_bank[i] <= w_wdata;
      end else if (clr) begin
        r_bank[i] <= 8'd0;
      end
    end
  end

  // Registered read with write-through bypass so rdata shows the post-edge bank contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 8'd0;
    end else if (w_commit && (w_waddr == raddr)) begin
      r_rdata <= w_wdata;
    end else if (clr) begin
      r_rdata <= 8'd0;
    end else begin
      r_rdata <= r_bank[raddr];
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed bench with a bank-level reference model
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        busy;
  logic        clr;
  logic [2:0]  raddr;
  logic [7:0]  rdata;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: bank contents, whose turn it is, and who (if anyone) holds the port.
  logic [7:0] m_bank [8];
  logic [7:0] m_rdata;
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_count;

  logic [3:0] seen [$];

  reg_bank_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .waddr(waddr), .wdata(wdata),
    .gnt(gnt), .busy(busy), .clr(clr), .raddr(raddr), .rdata(rdata),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge from the inputs currently applied.
  task automatic model_edge();
    logic [7:0] nb [8];
    int a;
    bit found;
    if (rst) begin
      foreach (m_bank[k]) m_bank[k] = 8'h00;
      m_rdata = 8'h00;
      m_busy  = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_count = 0;
    end else begin
      nb = m_bank;
      if (clr) foreach (nb[k]) nb[k] = 8'h00;
      if (m_busy) begin
        a = int'(waddr[3*m_owner +: 3]);
        nb[a] = wdata[8*m_owner +: 8];
      end
      m_bank  = nb;
      m_rdata = nb[raddr];
      if (m_busy) begin
        m_ptr  = (m_owner + 1) % 4;
        if (m_count < 65535) m_count++;
        m_busy = 0;
      end else if (req != 4'd0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            found   = 1;
          end
        end
        m_busy = 1;
      end
    end
  endtask

  // One clock: update model, let the edge pass, then compare everything away from the edge.
  task automatic step();
    logic [3:0] eg;
    model_edge();
    @(posedge clk);
    #1;
    eg = m_busy ? 4'(1 << m_owner) : 4'd0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("wr_count", 32'(wr_count), 32'(m_count));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    if (gnt != 4'd0) seen.push_back(gnt);
  endtask

  task automatic set_lane(input int i, input logic [2:0] a, input logic [7:0] d);
    waddr[3*i +: 3] = a;
    wdata[8*i +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] exp_seq [5];
  logic [3:0] mix_req [8];
  logic       mix_clr [8];

  initial begin
    rst = 1'b1; req = 4'd0; waddr = 12'd0; wdata = 32'd0; clr = 1'b0; raddr = 3'd0;
    foreach (m_bank[k]) m_bank[k] = 8'h00;
    m_rdata = 0; m_busy = 0; m_owner = 0; m_ptr = 0; m_count = 0;

    // Reset state.
    do_reset();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_count", 32'(wr_count), 32'd0);

    // Single write A5 -> reg 3, read back through the bypass.
    req = 4'b0001; set_lane(0, 3'd3, 8'hA5); raddr = 3'd3;
    step();
    chk("tc1_gnt", 32'(gnt), 32'h1);
    chk("tc1_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    chk("tc1_rdata", 32'(rdata), 32'hA5);
    chk("tc1_count", 32'(wr_count), 32'd1);
    step();
    chk("tc1_rdata_store", 32'(rdata), 32'hA5);

    // All four requesting from ptr=0: grants rotate on alternate cycles.
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 3'(i), 8'(8'h10 + i));
    req = 4'b1111;
    seen.delete();
    for (int c = 0; c < 10; c++) step();
    req = 4'b0000;
    step();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("tc2_ngrants", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) chk($sformatf("tc2_grant%0d", i), 32'(seen[i]), 32'(exp_seq[i]));
    end
    chk("tc2_count", 32'(wr_count), 32'd5);

    // Requester 2 granted last, then 0101: search wraps from 3 to 0, then 2.
    do_reset();
    req = 4'b0100; set_lane(2, 3'd2, 8'h22); set_lane(0, 3'd0, 8'h00);
    step();
    chk("tc3_first", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    req = 4'b0101;
    step();
    chk("tc3_wrap", 32'(gnt), 32'h1);
    step();
    step();
    chk("tc3_next", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();

    // Clear coinciding with a write of 3C to reg 5 over an all-FF bank.
    for (int i = 0; i < 8; i++) begin
      req = 4'b0001; set_lane(0, 3'(i), 8'hFF);
      step();
      req = 4'b0000;
      step();
    end
    req = 4'b0001; set_lane(0, 3'd5, 8'h3C);
    step();
    clr = 1'b1; req = 4'b0000;
    step();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr = 3'(i);
      step();
      chk($sformatf("tc4_reg%0d", i), 32'(rdata), (i == 5) ? 32'h3C : 32'h00);
    end

    // raddr held on reg 6 while 77 is written: old value, then bypassed new value.
    raddr = 3'd6; req = 4'b0001; set_lane(0, 3'd6, 8'h77);
    step();
    chk("tc5_before", 32'(rdata), 32'h00);
    req = 4'b0000;
    step();
    chk("tc5_bypass", 32'(rdata), 32'h77);

    // Mixed traffic with clears, checked only by the model.
    mix_req = '{4'b1010, 4'b0110, 4'b0000, 4'b1001, 4'b1111, 4'b0011, 4'b1000, 4'b0101};
    mix_clr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 3'((c + 2 * i) % 8), 8'(8'h40 + 16 * c + i));
      req = mix_req[c]; clr = mix_clr[c]; raddr = 3'((c * 3) % 8);
      step();
      req = 4'b0000; clr = 1'b0;
      step();
    end

    // Reset during GRANT discards the pending write and restarts the pointer.
    raddr = 3'd1; req = 4'b0010; set_lane(1, 3'd1, 8'h11);
    step();
    chk("tc6_granted", 32'(gnt), 32'h2);
    rst = 1'b1; req = 4'b0000;
    step();
    chk("tc6_gnt", 32'(gnt), 32'd0);
    chk("tc6_busy", 32'(busy), 32'd0);
    chk("tc6_count", 32'(wr_count), 32'd0);
    chk("tc6_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    step();
    chk("tc6_reg1", 32'(rdata), 32'd0);
    req = 4'b1111;
    step();
    chk("tc6_ptr0", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
